// File: rtl/follower_obstacles_pkg.sv
// Shared screen geometry, LFSR constants and coordinate type for the obstacle pipeline.
package follower_obstacles_pkg;
   localparam int          SCREEN_W    = 640;
   localparam int          SCREEN_H    = 480;
   localparam int          OB_Y_OFFSET = 150;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;
   localparam logic [15:0] LFSR_MASK   = 16'hB400;

   typedef logic [9:0] coord_t;

   // Single subtract suffices: callers never exceed 2*SCREEN_H-1.
   function automatic coord_t wrap_y(input coord_t s);
      return (s >= coord_t'(SCREEN_H)) ? s - coord_t'(SCREEN_H) : s;
   endfunction
endpackage

// File: rtl/follower_obstacles_if.sv
// Scroll-stage inputs, VGA position, player box and obstacle outputs.
interface follower_obstacles_if;
   import follower_obstacles_pkg::*;
   coord_t y_pos;
   logic   move_followers;
   coord_t hpos;
   coord_t vpos;
   coord_t player_x;
   coord_t player_y;
   logic   ob_pixel;
   logic   collision;
   coord_t lead_x;

   modport master (output y_pos, move_followers, hpos, vpos, player_x, player_y,
                   input  ob_pixel, collision, lead_x);
   modport slave  (input  y_pos, move_followers, hpos, vpos, player_x, player_y,
                   output ob_pixel, collision, lead_x);
endinterface

// File: rtl/follower_obstacles_lfsr16.sv
// Free-running 16-bit Galois LFSR used to place obstacles horizontally.
module lfsr16
   import follower_obstacles_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] state
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= SEED;
      else
         state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
   end
endmodule

// File: rtl/follower_obstacles.sv
// Follower obstacle rows spaced below the lead row, with pixel and sticky collision outputs.
module follower_obstacles
   import follower_obstacles_pkg::*;
#(
   parameter int NUM_OB     = 4,
   parameter int OB_SPACING = 120,
   parameter int OB_W       = 64,
   parameter int OB_H       = 16,
   parameter int PLAYER_W   = 16,
   parameter int PLAYER_H   = 16
) (
   input logic                 clk,
   input logic                 reset,
   follower_obstacles_if.slave bus
);
   coord_t      fy     [NUM_OB];
   coord_t      fx     [NUM_OB];
   coord_t      new_fy [NUM_OB];
   coord_t      new_fx [NUM_OB];
   logic [15:0] lfsr_state;
   logic        tick_d;
   logic        ob_pixel_q;
   logic        collision_q;
   logic [NUM_OB-1:0] row_wraps;
   logic [NUM_OB-1:0] row_pix;
   logic [NUM_OB-1:0] row_hit;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .state (lfsr_state)
   );

   // 11-bit compares keep player_x + PLAYER_W from overflowing.
   for (genvar k = 0; k < NUM_OB; k++) begin : g_row
      localparam coord_t ROW_OFF = coord_t'(k * OB_SPACING);
      logic [10:0] ox, oy, hx, hy, px, py;
      assign ox = {1'b0, fx[k]};
      assign oy = {1'b0, fy[k]};
      assign hx = {1'b0, bus.hpos};
      assign hy = {1'b0, bus.vpos};
      assign px = {1'b0, bus.player_x};
      assign py = {1'b0, bus.player_y};

      assign new_fy[k]    = wrap_y(bus.y_pos + ROW_OFF);
      assign row_wraps[k] = new_fy[k] < fy[k];
      assign row_pix[k]   = (hx >= ox) && (hx < ox + 11'(OB_W)) &&
                            (hy >= oy) && (hy < oy + 11'(OB_H));
      assign row_hit[k]   = (px < ox + 11'(OB_W)) && (ox < px + 11'(PLAYER_W)) &&
                            (py < oy + 11'(OB_H)) && (oy < py + 11'(PLAYER_H));
   end

   // Lowest wrapping row takes the low LFSR slice, any others the high slice.
   always_comb begin
      logic taken;
      taken = 1'b0;
      for (int k = 0; k < NUM_OB; k++) begin
         new_fx[k] = fx[k];
         if (row_wraps[k]) begin
            new_fx[k] = taken ? {1'b0, lfsr_state[15:7]} : {1'b0, lfsr_state[8:0]};
            taken     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_OB; k++) begin
            fy[k] <= wrap_y(coord_t'(OB_Y_OFFSET + k * OB_SPACING));
            fx[k] <= coord_t'(64 + k * 128);
         end
         tick_d      <= 1'b0;
         ob_pixel_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         tick_d     <= bus.move_followers;
         ob_pixel_q <= |row_pix;
         if (tick_d && |row_hit)
            collision_q <= 1'b1;
         if (bus.move_followers) begin
            for (int k = 0; k < NUM_OB; k++) begin
               fy[k] <= new_fy[k];
               fx[k] <= new_fx[k];
            end
         end
      end
   end

   assign bus.ob_pixel  = ob_pixel_q;
   assign bus.collision = collision_q;
   assign bus.lead_x    = fx[0];
endmodule
